// File: rtl/ls48_pkg.sv
// rtl/ls48_pkg.sv - shared BCD constants, speed-select codes and nibble clamp helper
package ls48_pkg;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    // speed_sel encodings: index into the edge-detect vector
    typedef enum logic [1:0] {
        SPEED_1HZ  = 2'd0,
        SPEED_2HZ  = 2'd1,
        SPEED_4HZ  = 2'd2,
        SPEED_10HZ = 2'd3
    } speed_e;

    // Force any nibble above 9 to 9 so a bad load can never produce a non-BCD digit
    function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] v);
        return (v > BCD_MAX) ? BCD_MAX : v;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one BCD decade with clear, load and up/down step
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   en            : advance one step in direction dir this cycle
//   dir           : 1 = up, 0 = down
//   clr           : force digit to 0 (highest priority after rst)
//   ld, ld_val    : force digit to ld_val
//   max_digit     : roll-over point going up / reload value going down
//   digit         : current digit value
//   terminal      : digit is at max_digit (dir=1) or at 0 (dir=0)
module bcd_digit
    import ls48_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             clr,
    input  logic             ld,
    input  logic [BCD_W-1:0] ld_val,
    input  logic [BCD_W-1:0] max_digit,
    output logic [BCD_W-1:0] digit,
    output logic             terminal
);

    logic [BCD_W-1:0] digit_q;
    logic [BCD_W-1:0] digit_d;

    always_comb begin
        digit_d = digit_q;
        if (clr) begin
            digit_d = '0;
        end else if (ld) begin
            digit_d = ld_val;
        end else if (en) begin
            if (dir) begin
                // >= rather than == keeps a stray value from counting past the limit
                digit_d = (digit_q >= max_digit) ? '0 : digit_q + 4'd1;
            end else begin
                digit_d = (digit_q == '0) ? max_digit : digit_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit    = digit_q;
    assign terminal = dir ? (digit_q == max_digit) : (digit_q == '0);

endmodule

// File: rtl/bcd_tick_counter.sv
// rtl/bcd_tick_counter.sv - two-digit BCD up/down counter stepped by a selected divided clock
//
// Ports:
//   clk_50M, rst                      : system clock, synchronous active-high reset
//   clk_1hz/2hz/4hz/10hz              : divided clock levels, sampled as data
//   speed_sel                         : which divided clock steps the counter
//   run, dir, clear, load             : count enable, direction, clear to 00, load
//   load_tens, load_ones              : BCD value for load (clamped)
//   blink_en                          : allow blanking while paused
//   bcd_tens, bcd_ones                : digits to the LS48 decoders
//   tick, wrap                        : single-cycle step / wrap-around pulses
//   blank                             : 1 = blank the display
module bcd_tick_counter
    import ls48_pkg::*;
#(
    parameter int MAX_VAL        = 99,
    parameter int BLINK_ON_PAUSE = 1
) (
    input  logic             clk_50M,
    input  logic             rst,
    input  logic             clk_1hz,
    input  logic             clk_2hz,
    input  logic             clk_4hz,
    input  logic             clk_10hz,
    input  logic [1:0]       speed_sel,
    input  logic             run,
    input  logic             dir,
    input  logic             clear,
    input  logic             load,
    input  logic [BCD_W-1:0] load_tens,
    input  logic [BCD_W-1:0] load_ones,
    input  logic             blink_en,
    output logic [BCD_W-1:0] bcd_tens,
    output logic [BCD_W-1:0] bcd_ones,
    output logic             tick,
    output logic             wrap,
    output logic             blank
);

    localparam logic [BCD_W-1:0] MAX_TENS = BCD_W'(MAX_VAL / 10);
    localparam logic [BCD_W-1:0] MAX_ONES = BCD_W'(MAX_VAL % 10);

    logic [3:0] clk_lvl;
    logic [3:0] prev_q, prev_d;
    logic [3:0] edge_vec;
    logic       edge_sel;

    logic       tick_q, tick_d;
    logic       wrap_q, wrap_d;
    logic       blank_q, blank_d;

    logic       step, at_max, at_zero, up_wrap, dn_wrap;
    logic [BCD_W-1:0] clamp_tens, clamp_ones, ld_tens, ld_ones;
    logic       over_max;

    logic       digit_clr, digit_ld, ones_en, tens_en;
    logic [BCD_W-1:0] ones_ld_val, tens_ld_val;
    logic       ones_terminal, tens_terminal;

    // Bit order matches the speed_sel codes
    assign clk_lvl = {clk_10hz, clk_4hz, clk_2hz, clk_1hz};

    // Detect on all four sources, then select: switching speed_sel onto a
    // source that is already high sees its prev=1 and produces nothing.
    assign edge_vec = clk_lvl & ~prev_q;
    assign edge_sel = edge_vec[speed_sel];

    always_comb begin
        prev_d = clk_lvl;

        step    = run & edge_sel & ~clear & ~load;
        at_max  = (bcd_tens == MAX_TENS) && (bcd_ones == MAX_ONES);
        at_zero = (bcd_tens == '0) && (bcd_ones == '0);
        up_wrap = step & dir & at_max;
        dn_wrap = step & ~dir & at_zero;

        // Per-nibble BCD clamp first, then clamp the whole value to MAX_VAL
        clamp_tens = bcd_clamp(load_tens);
        clamp_ones = bcd_clamp(load_ones);
        over_max   = (clamp_tens > MAX_TENS) ||
                     ((clamp_tens == MAX_TENS) && (clamp_ones > MAX_ONES));
        ld_tens    = over_max ? MAX_TENS : clamp_tens;
        ld_ones    = over_max ? MAX_ONES : clamp_ones;

        // Both wraps are expressed as whole-value clear/load of the two digits,
        // so the digits only ever handle plain 0..9 stepping.
        digit_clr   = clear | up_wrap;
        digit_ld    = load | dn_wrap;
        tens_ld_val = dn_wrap ? MAX_TENS : ld_tens;
        ones_ld_val = dn_wrap ? MAX_ONES : ld_ones;
        ones_en     = step & ~up_wrap & ~dn_wrap;
        tens_en     = ones_en & ones_terminal;

        tick_d  = step;
        wrap_d  = up_wrap | dn_wrap;
        blank_d = (BLINK_ON_PAUSE != 0) & blink_en & ~run & clk_2hz;
    end

    always_ff @(posedge clk_50M) begin
        if (rst) begin
            // Load current levels so a source already high at release is not a tick
            prev_q  <= clk_lvl;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
            blank_q <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
            blank_q <= blank_d;
        end
    end

    bcd_digit u_ones (
        .clk       (clk_50M),
        .rst       (rst),
        .en        (ones_en),
        .dir       (dir),
        .clr       (digit_clr),
        .ld        (digit_ld),
        .ld_val    (ones_ld_val),
        .max_digit (BCD_MAX),
        .digit     (bcd_ones),
        .terminal  (ones_terminal)
    );

    bcd_digit u_tens (
        .clk       (clk_50M),
        .rst       (rst),
        .en        (tens_en),
        .dir       (dir),
        .clr       (digit_clr),
        .ld        (digit_ld),
        .ld_val    (tens_ld_val),
        .max_digit (BCD_MAX),
        .digit     (bcd_tens),
        .terminal  (tens_terminal)
    );

    assign tick  = tick_q;
    assign wrap  = wrap_q;
    assign blank = blank_q;

endmodule

// File: tb/tb_bcd_tick_counter.sv
// tb/tb_bcd_tick_counter.sv - scoreboard bench for bcd_tick_counter (MAX_VAL 99 and 59)
module tb_bcd_tick_counter;
    import ls48_pkg::*;

    logic       clk_50M = 1'b0;
    logic       rst = 1'b1;
    logic       clk_1hz = 1'b0, clk_2hz = 1'b0, clk_4hz = 1'b0, clk_10hz = 1'b1;
    logic [1:0] speed_sel = SPEED_10HZ;
    logic       run = 1'b0, run59 = 1'b0, dir = 1'b1, clear = 1'b0, load = 1'b0;
    logic [3:0] load_tens = 4'd0, load_ones = 4'd0;
    logic       blink_en = 1'b0;

    logic [3:0] bcd_tens, bcd_ones, tens59, ones59;
    logic       tick, wrap, blank, tick59, wrap59, blank59;

    int n_checks = 0;
    int n_fail   = 0;

    // expected {tens, ones, wrap} for each tick
    logic [8:0] exp_q[$];
    logic [8:0] exp59_q[$];

    always #5 clk_50M = ~clk_50M;

    bcd_tick_counter #(.MAX_VAL(99), .BLINK_ON_PAUSE(1)) dut (
        .clk_50M(clk_50M), .rst(rst),
        .clk_1hz(clk_1hz), .clk_2hz(clk_2hz), .clk_4hz(clk_4hz), .clk_10hz(clk_10hz),
        .speed_sel(speed_sel), .run(run), .dir(dir), .clear(clear), .load(load),
        .load_tens(load_tens), .load_ones(load_ones), .blink_en(blink_en),
        .bcd_tens(bcd_tens), .bcd_ones(bcd_ones), .tick(tick), .wrap(wrap), .blank(blank)
    );

    bcd_tick_counter #(.MAX_VAL(59), .BLINK_ON_PAUSE(1)) dut59 (
        .clk_50M(clk_50M), .rst(rst),
        .clk_1hz(clk_1hz), .clk_2hz(clk_2hz), .clk_4hz(clk_4hz), .clk_10hz(clk_10hz),
        .speed_sel(speed_sel), .run(run59), .dir(dir), .clear(clear), .load(load),
        .load_tens(load_tens), .load_ones(load_ones), .blink_en(blink_en),
        .bcd_tens(tens59), .bcd_ones(ones59), .tick(tick59), .wrap(wrap59), .blank(blank59)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_50M);
        #1;
    endtask

    // one clk_10hz period of 6 cycles; the rise is seen at the first posedge
    task automatic edge10();
        clk_10hz = 1'b1;
        cyc(3);
        clk_10hz = 1'b0;
        cyc(3);
    endtask

    // Monitors: every tick pops one expectation; a tick with nothing expected is a failure
    always @(negedge clk_50M) begin
        if (!rst) begin
            if (tick) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL spurious_tick: got %0d%0d wrap=%0d, none expected",
                             bcd_tens, bcd_ones, wrap);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    if ({bcd_tens, bcd_ones, wrap} != e) begin
                        n_fail++;
                        $display("FAIL tick_value: got %0d%0d wrap=%0d expected %0d%0d wrap=%0d",
                                 bcd_tens, bcd_ones, wrap, e[8:5], e[4:1], e[0]);
                    end
                end
            end else if (wrap) begin
                n_checks++;
                n_fail++;
                $display("FAIL wrap_without_tick: got wrap=1 expected 0");
            end
            if (tick59) begin
                n_checks++;
                if (exp59_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL spurious_tick59: got %0d%0d, none expected", tens59, ones59);
                end else begin
                    logic [8:0] e;
                    e = exp59_q.pop_front();
                    if ({tens59, ones59, wrap59} != e) begin
                        n_fail++;
                        $display("FAIL tick59_value: got %0d%0d wrap=%0d expected %0d%0d wrap=%0d",
                                 tens59, ones59, wrap59, e[8:5], e[4:1], e[0]);
                    end
                end
            end
        end
    end

    initial begin
        // Reset with clk_10hz already high: release must not tick
        cyc(2);
        rst = 1'b0;
        cyc(2);
        check("reset_tens", bcd_tens, 0);
        check("reset_ones", bcd_ones, 0);
        check("reset_blank", blank, 0);
        check("reset_tick", tick, 0);

        // Count up 10 steps at 10 Hz: 00 -> 10, tick one cycle after each rise
        speed_sel = SPEED_10HZ;
        run = 1'b1;
        dir = 1'b1;
        clk_10hz = 1'b0;
        cyc(3);
        for (int i = 1; i <= 10; i++) begin
            exp_q.push_back({4'(i / 10), 4'(i % 10), 1'b0});
            clk_10hz = 1'b1;
            cyc(1);
            check("tick_latency", tick, 1);
            cyc(2);
            clk_10hz = 1'b0;
            cyc(3);
        end
        check("count10_tens", bcd_tens, 1);
        check("count10_ones", bcd_ones, 0);

        // Load 98, up twice: 99 then 00 with wrap only on the second
        load_tens = 4'd9;
        load_ones = 4'd8;
        load = 1'b1;
        cyc(1);
        load = 1'b0;
        check("load98_tens", bcd_tens, 9);
        check("load98_ones", bcd_ones, 8);
        check("load_no_tick", tick, 0);
        exp_q.push_back({4'd9, 4'd9, 1'b0});
        edge10();
        exp_q.push_back({4'd0, 4'd0, 1'b1});
        edge10();

        // Down from 00: wrap to 99, then 98
        dir = 1'b0;
        exp_q.push_back({4'd9, 4'd9, 1'b1});
        edge10();
        exp_q.push_back({4'd9, 4'd8, 1'b0});
        edge10();

        // MAX_VAL=59 instance: load 59, one up step wraps to 00
        dir = 1'b1;
        load_tens = 4'd5;
        load_ones = 4'd9;
        load = 1'b1;
        cyc(1);
        load = 1'b0;
        check("load59_tens59", tens59, 5);
        check("load59_ones59", ones59, 9);
        run59 = 1'b1;
        exp_q.push_back({4'd6, 4'd0, 1'b0});
        exp59_q.push_back({4'd0, 4'd0, 1'b1});
        edge10();
        // Down from 00 on the 59 instance wraps to 59
        dir = 1'b0;
        exp_q.push_back({4'd5, 4'd9, 1'b0});
        exp59_q.push_back({4'd5, 4'd9, 1'b1});
        edge10();
        run59 = 1'b0;
        dir = 1'b1;

        // Load 73: clamped to MAX_VAL on the 59 instance only
        load_tens = 4'd7;
        load_ones = 4'd3;
        load = 1'b1;
        cyc(1);
        load = 1'b0;
        check("load73_tens", bcd_tens, 7);
        check("load73_ones", bcd_ones, 3);
        check("load73_tens59", tens59, 5);
        check("load73_ones59", ones59, 9);

        // clk_10hz rises while 1 Hz is selected, then switch to 10 Hz while it is high
        speed_sel = SPEED_1HZ;
        clk_10hz = 1'b1;
        cyc(3);
        speed_sel = SPEED_10HZ;
        cyc(1);
        check("switch_no_tick", tick, 0);
        cyc(2);
        check("switch_hold_ones", bcd_ones, 3);
        clk_10hz = 1'b0;
        cyc(3);

        // clear and load together with an edge: clear wins, no tick
        clear = 1'b1;
        load = 1'b1;
        load_tens = 4'd5;
        load_ones = 4'd5;
        clk_10hz = 1'b1;
        cyc(1);
        clear = 1'b0;
        load = 1'b0;
        check("clear_tens", bcd_tens, 0);
        check("clear_ones", bcd_ones, 0);
        check("clear_no_tick", tick, 0);
        cyc(2);
        clk_10hz = 1'b0;
        cyc(3);

        // Paused: blank follows clk_2hz one cycle late; edges are discarded
        run = 1'b0;
        blink_en = 1'b1;
        clk_2hz = 1'b1;
        clk_10hz = 1'b1;
        cyc(1);
        check("blank_high", blank, 1);
        clk_2hz = 1'b0;
        cyc(1);
        check("blank_low", blank, 0);
        // resuming while clk_10hz is still high must not replay the discarded edge
        run = 1'b1;
        cyc(2);
        check("pause_hold_ones", bcd_ones, 0);
        run = 1'b0;
        clk_10hz = 1'b0;
        clk_2hz = 1'b1;
        blink_en = 1'b0;
        cyc(2);
        check("blank_disabled", blank, 0);
        clk_2hz = 1'b0;

        // Non-BCD load clamps to 99 / 59
        load_tens = 4'd12;
        load_ones = 4'd15;
        load = 1'b1;
        cyc(1);
        load = 1'b0;
        check("clamp_tens", bcd_tens, 9);
        check("clamp_ones", bcd_ones, 9);
        check("clamp_tens59", tens59, 5);
        check("clamp_ones59", ones59, 9);

        cyc(5);
        check("queue_drained", exp_q.size(), 0);
        check("queue59_drained", exp59_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
